// File: rtl/mips_mem_pkg.sv
// Shared size/state encodings for the MIPS store serializer.
// Byte-count helper maps a store size to its number of bytes.
package mips_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      logic [2:0] n;
      case (sz)
         SZ_HALF: n = 3'd2;
         SZ_WORD: n = 3'd4;
         default: n = 3'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mips_store_serializer_if.sv
// Request handshake and byte-wide memory port of the store serializer.
// slave = serializer side, master = datapath/memory side.
interface mips_store_serializer_if #(
   parameter int ADDR_W = 32
);

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_data;
   logic [1:0]        req_size;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_ack;
   logic              done;
   logic              err;

   modport slave (
      input  req_valid, req_addr, req_data, req_size, mem_ack,
      output req_ready, mem_we, mem_addr, mem_wdata, done, err
   );

   modport master (
      output req_valid, req_addr, req_data, req_size, mem_ack,
      input  req_ready, mem_we, mem_addr, mem_wdata, done, err
   );

endinterface

// File: rtl/mips_store_byte_sel.sv
// Big-endian byte picker: index 0 is the most significant stored byte.
// Bits above the stored width never reach the output.
module mips_store_byte_sel
   import mips_mem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  idx_i,
   input  logic [31:0] data_i,
   output logic [7:0]  byte_o
);

   always_comb begin
      byte_o = data_i[7:0];
      unique case (1'b1)
         (size_i == SZ_WORD): begin
            case (idx_i)
               2'd0:    byte_o = data_i[31:24];
               2'd1:    byte_o = data_i[23:16];
               2'd2:    byte_o = data_i[15:8];
               default: byte_o = data_i[7:0];
            endcase
         end
         (size_i == SZ_HALF): begin
            byte_o = idx_i[0] ? data_i[7:0] : data_i[15:8];
         end
         default: byte_o = data_i[7:0];
      endcase
   end

endmodule

// File: rtl/mips_store_serializer.sv
// Narrows a store to byte/half/word and writes it one byte per cycle.
// Define MISALIGN_CHECK_EN to reject misaligned half/word stores.
module mips_store_serializer
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mips_store_serializer_if.slave bus
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [1:0]        size_q, size_d;
   logic [1:0]        idx_q, idx_d;
   logic              err_q, err_d;
   logic              illegal;
   logic              last;
   logic [2:0]        nbytes;
   logic [7:0]        sel_byte;

`ifdef MISALIGN_CHECK_EN
   assign illegal = (bus.req_size == SZ_RSVD)
                 | ((bus.req_size == SZ_HALF) & bus.req_addr[0])
                 | ((bus.req_size == SZ_WORD) & (|bus.req_addr[1:0]));
`else
   assign illegal = (bus.req_size == SZ_RSVD);
`endif

   assign nbytes = size_bytes(size_q);
   assign last   = (idx_q == nbytes[1:0] - 2'd1);

   mips_store_byte_sel u_sel (
      .size_i (size_q),
      .idx_i  (idx_q),
      .data_i (data_q),
      .byte_o (sel_byte)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         size_q  <= SZ_BYTE;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         size_q  <= size_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      size_d  = size_q;
      idx_d   = idx_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               data_d  = bus.req_data;
               size_d  = bus.req_size;
               idx_d   = 2'd0;
               err_d   = illegal;
               state_d = illegal ? ST_RESP : ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (bus.mem_ack) begin
               if (last) state_d = ST_RESP;
               else      idx_d   = idx_q + 2'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decode from state only so reset clears them at once.
   always_comb begin
      bus.req_ready = (state_q == ST_IDLE);
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.done      = 1'b0;
      bus.err       = 1'b0;
      if (state_q == ST_WRITE) begin
         bus.mem_we    = 1'b1;
         bus.mem_addr  = addr_q + ADDR_W'(idx_q);
         bus.mem_wdata = sel_byte;
      end
      if (state_q == ST_RESP) begin
         bus.done = ~err_q;
         bus.err  = err_q;
      end
   end

endmodule
